ntt_r16_agu: RTL and testbench

Radix-16 NTT address generation unit. For each cycle it emits the 16 memory-address indices (MA) and 16 bank-number indices (BN) of one radix-16 butterfly group, using a conflict-free digit-sum bank mapping. It sits directly upstream of the index delay buffer. Its `ntt_enable` output is the per-cycle valid flag that the delay buffer carries forward to produce `ntt_done_pip_out`.

---
 rtl/ntt_r16_agu_pkg.sv | 8 +
 rtl/ntt_r16_agu_if.sv | 14 +
 rtl/r16_bank_map.sv | 19 +
 rtl/ntt_r16_agu.sv | 108 ++++++++++
 tb/tb_ntt_r16_agu.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/ntt_r16_agu_pkg.sv
// Shared constants and FSM state type for the radix-16 NTT address generator.
package ntt_r16_agu_pkg;
  localparam int STAGES    = 3;
  localparam int R16_LANES = 16;
  localparam int D_width   = 4*(STAGES-1);

  typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} agu_state_t;
endpackage

// File: rtl/ntt_r16_agu_if.sv
// Control/status and per-lane MA/BN bus between the AGU and its host / delay buffer.
interface ntt_r16_agu_if import ntt_r16_agu_pkg::*; #(parameter int DW = D_width);
  logic                         start;
  logic                         stall;
  logic                         busy;
  logic                         ntt_enable;
  logic                         ntt_done;
  logic [1:0]                   stage_idx;
  logic [R16_LANES-1:0][DW-1:0] ma;
  logic [R16_LANES-1:0][DW-1:0] bn;

  modport agu  (input start, stall, output busy, ntt_enable, ntt_done, stage_idx, ma, bn);
  modport host (output start, stall, input busy, ntt_enable, ntt_done, stage_idx, ma, bn);
endinterface

// File: rtl/r16_bank_map.sv
// Splits a full butterfly index into memory address (index >> 4) and digit-sum bank.
module r16_bank_map import ntt_r16_agu_pkg::*; #(
  parameter int NST = STAGES,
  parameter int DW  = D_width
) (
  input  logic [4*NST-1:0] i_idx,
  output logic [DW-1:0]    o_ma,
  output logic [DW-1:0]    o_bn
);
  logic [3:0] w_sum;

  // 4-bit accumulator wraps, giving the mod-16 digit sum directly
  always_comb begin
    w_sum = '0;
    for (int d = 0; d < NST; d++) w_sum = w_sum + i_idx[4*d +: 4];
    o_ma = DW'(i_idx[4*NST-1:4]);
    o_bn = DW'(w_sum);
  end
endmodule

// File: rtl/ntt_r16_agu.sv
// Radix-16 NTT AGU: FSM, group/gap/stage counters, lane-digit insertion, registered MA/BN.
module ntt_r16_agu import ntt_r16_agu_pkg::*; #(
  parameter int STAGES    = ntt_r16_agu_pkg::STAGES,
  parameter int STAGE_GAP = 12,
  parameter int D_width   = ntt_r16_agu_pkg::D_width
) (
  input  logic       clk,
  input  logic       rst_n,
  ntt_r16_agu_if.agu bus
);
  localparam int GW  = 4*(STAGES-1);
  localparam int IW  = 4*STAGES;
  localparam int GPW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  localparam logic [GW-1:0] LAST_G = '1;

  logic [1:0]    r_rsync;
  logic          w_rst_n;
  agu_state_t    r_state;
  logic [GW-1:0] r_grp;
  logic [GPW-1:0] r_gap;
  logic [1:0]    r_stage;
  logic          r_busy, r_en, r_done;
  logic [R16_LANES-1:0][D_width-1:0] r_ma, r_bn, w_ma, w_bn;
  logic [1:0]    w_pos;
  logic [IW-1:0] w_gx, w_lo;
  logic          w_start_ok;

  // assert immediately, release two clocks after rst_n rises
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_rsync <= '0;
    else        r_rsync <= {r_rsync[0], 1'b1};
  assign w_rst_n = r_rsync[1];

  // lane digit goes at position STAGES-1-stage; group digits fill the rest in order
  assign w_pos = 2'(STAGES-1) - r_stage;
  assign w_gx  = IW'(r_grp);
  assign w_lo  = (IW'(1) << {w_pos, 2'b00}) - IW'(1);

  for (genvar k = 0; k < R16_LANES; k++) begin : g_lane
    logic [IW-1:0] w_idx;
    assign w_idx = ((w_gx & ~w_lo) << 4) | (IW'(k) << {w_pos, 2'b00}) | (w_gx & w_lo);
    r16_bank_map #(.NST(STAGES), .DW(D_width)) u_map (
      .i_idx (w_idx),
      .o_ma  (w_ma[k]),
      .o_bn  (w_bn[k])
    );
  end

  // a start coinciding with the done pulse is dropped
  assign w_start_ok = bus.start && !r_done;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= IDLE;
      r_grp   <= '0;
      r_gap   <= '0;
      r_stage <= '0;
      r_busy  <= 1'b0;
      r_en    <= 1'b0;
      r_done  <= 1'b0;
      r_ma    <= '0;
      r_bn    <= '0;
    end else begin
      r_en   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_busy <= w_start_ok;
          if (w_start_ok) begin
            r_state <= RUN;
            r_grp   <= '0;
            r_stage <= '0;
          end
        end
        RUN: if (!bus.stall) begin
          r_en  <= 1'b1;
          r_ma  <= w_ma;
          r_bn  <= w_bn;
          r_grp <= r_grp + 1'b1;
          if (r_grp == LAST_G) begin
            r_gap   <= '0;
            r_state <= (r_stage == 2'(STAGES-1)) ? DONE : GAP;
          end
        end
        GAP: begin
          r_gap <= r_gap + 1'b1;
          if (r_gap == GPW'(STAGE_GAP-1)) begin
            r_stage <= r_stage + 1'b1;
            r_grp   <= '0;
            r_state <= RUN;
          end
        end
        DONE: begin
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.ntt_enable = r_en;
  assign bus.ntt_done   = r_done;
  assign bus.stage_idx  = r_stage;
  assign bus.ma         = r_ma;
  assign bus.bn         = r_bn;
endmodule

// File: tb/tb_ntt_r16_agu.sv
// Directed bench for ntt_r16_agu: lane-value table, run timing, stall, ignored start, mid-run reset.
module tb_ntt_r16_agu;
  import ntt_r16_agu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ntt_r16_agu_if bus();
  ntt_r16_agu dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct { int s; int g; int k; int ma; int bn; } vec_t;
  vec_t tbl [13];

  int checks = 0, errors = 0;
  int cyc = 0, t0 = 0;
  int en_cnt, done_cnt, done_cyc, first_en_cyc, busy_fall_cyc, low_run, bn_viol, g100_cnt;
  bit seen_high, prev_busy;
  int gaps [$];
  int grp_cnt [3];
  logic [7:0] cap_ma [3][256][16];
  logic [7:0] cap_bn [3][256][16];
  logic [15:0] m_seen;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    en_cnt = 0; done_cnt = 0; done_cyc = -1; first_en_cyc = -1; busy_fall_cyc = -1;
    low_run = 0; bn_viol = 0; g100_cnt = 0; seen_high = 0;
    gaps.delete();
    for (int s = 0; s < 3; s++) begin
      grp_cnt[s] = 0;
      for (int g = 0; g < 256; g++)
        for (int k = 0; k < 16; k++) begin cap_ma[s][g][k] = 8'hxx; cap_bn[s][g][k] = 8'hxx; end
    end
  endtask

  // passive monitor, samples on the falling edge
  always @(negedge clk) begin
    if (prev_busy && !bus.busy && busy_fall_cyc < 0) busy_fall_cyc = cyc;
    prev_busy = bus.busy;
    if (bus.ntt_done) begin done_cnt++; done_cyc = cyc; end
    if (bus.ntt_enable) begin
      en_cnt++;
      if (first_en_cyc < 0) first_en_cyc = cyc;
      if (seen_high && low_run > 0) gaps.push_back(low_run);
      low_run = 0;
      seen_high = 1;
      if (bus.stage_idx < 2'd3 && grp_cnt[bus.stage_idx] < 256) begin
        for (int k = 0; k < 16; k++) begin
          cap_ma[bus.stage_idx][grp_cnt[bus.stage_idx]][k] = bus.ma[k];
          cap_bn[bus.stage_idx][grp_cnt[bus.stage_idx]][k] = bus.bn[k];
        end
        grp_cnt[bus.stage_idx]++;
      end
      m_seen = '0;
      for (int k = 0; k < 16; k++) m_seen[bus.bn[k][3:0]] = 1'b1;
      if (m_seen != 16'hFFFF) bn_viol++;
      if (bus.stage_idx == 2'd0 && bus.ma[0] == 8'd6 && bus.bn[0] == 8'd10) g100_cnt++;
    end else if (bus.busy && seen_high) begin
      low_run++;
    end
  end

  task automatic pulse_start();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    t0 = cyc;
    #1;
    chk("busy_rise", int'(bus.busy), 1);
    chk("no_enable_at_accept", int'(bus.ntt_enable), 0);
  endtask

  task automatic wait_done(input int budget, input int mid_at, input bit sod);
    int n = 0;
    bit got = 0;
    while (!got && n < budget) begin
      @(negedge clk); #1; n++;
      bus.start = 1'b0;
      if (n == mid_at) bus.start = 1'b1;
      if (bus.ntt_done) begin got = 1; if (sod) bus.start = 1'b1; end
    end
    chk("done_seen", int'(got), 1);
    @(negedge clk); #1 bus.start = 1'b0;
  endtask

  task automatic wait_group(input string name, input int st, input int ma0, input int bn0, input int budget);
    bit got = 0;
    for (int n = 0; n < budget && !got; n++) begin
      @(negedge clk); #1;
      if (bus.ntt_enable && bus.stage_idx == 2'(st) && bus.ma[0] == 8'(ma0) && bus.bn[0] == 8'(bn0)) got = 1;
    end
    chk(name, int'(got), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit held_ok;
    tbl[0]  = '{0,   0,  0,   0,  0};
    tbl[1]  = '{0,   0,  5,  80,  5};
    tbl[2]  = '{0,   0, 15, 240, 15};
    tbl[3]  = '{1,   1,  0,   0,  1};
    tbl[4]  = '{1,   1,  7,   7,  8};
    tbl[5]  = '{1,   1, 15,  15,  0};
    tbl[6]  = '{2,   0,  3,   0,  3};
    tbl[7]  = '{2,   0, 15,   0, 15};
    tbl[8]  = '{0, 100,  0,   6, 10};
    tbl[9]  = '{0, 100,  9, 150,  3};
    tbl[10] = '{2, 255,  4, 255,  2};
    tbl[11] = '{1,  42,  3,  35, 15};
    tbl[12] = '{0, 255,  1,  31, 15};

    bus.start = 1'b0;
    bus.stall = 1'b0;
    clear_stats();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_enable", int'(bus.ntt_enable), 0);
    chk("rst_done", int'(bus.ntt_done), 0);
    chk("rst_stage", int'(bus.stage_idx), 0);
    chk("rst_ma_or", int'(|bus.ma), 0);
    chk("rst_bn_or", int'(|bus.bn), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // full run, start pulsed mid-run and again in the done cycle
    clear_stats();
    pulse_start();
    wait_done(1000, 300, 1'b1);
    repeat (6) @(negedge clk);
    #1;
    chk("enable_count", en_cnt, 768);
    chk("gap_count", gaps.size(), 2);
    chk("gap0_len", (gaps.size() > 0) ? gaps[0] : -1, 12);
    chk("gap1_len", (gaps.size() > 1) ? gaps[1] : -1, 12);
    chk("done_pulses", done_cnt, 1);
    chk("done_latency", done_cyc - t0, 793);
    chk("first_valid_latency", first_en_cyc - t0, 1);
    chk("busy_fall_after_done", busy_fall_cyc - done_cyc, 1);
    chk("no_restart_busy", int'(bus.busy), 0);
    chk("stage0_groups", grp_cnt[0], 256);
    chk("stage1_groups", grp_cnt[1], 256);
    chk("stage2_groups", grp_cnt[2], 256);
    chk("bn_distinct_violations", bn_viol, 0);
    foreach (tbl[i]) begin
      chk($sformatf("ma_s%0d_g%0d_k%0d", tbl[i].s, tbl[i].g, tbl[i].k),
          int'(cap_ma[tbl[i].s][tbl[i].g][tbl[i].k]), tbl[i].ma);
      chk($sformatf("bn_s%0d_g%0d_k%0d", tbl[i].s, tbl[i].g, tbl[i].k),
          int'(cap_bn[tbl[i].s][tbl[i].g][tbl[i].k]), tbl[i].bn);
    end

    // 5-cycle stall right after stage 0 group 100 is emitted
    clear_stats();
    pulse_start();
    wait_group("found_s0_g100", 0, 6, 10, 400);
    bus.stall = 1'b1;
    held_ok = 1;
    repeat (5) begin
      @(negedge clk); #1;
      if (!(bus.ntt_enable == 1'b0 && bus.ma[0] == 8'd6 && bus.bn[0] == 8'd10 &&
            bus.ma[9] == 8'd150 && bus.bn[9] == 8'd3)) held_ok = 0;
    end
    bus.stall = 1'b0;
    chk("stall_hold", int'(held_ok), 1);
    @(negedge clk); #1;
    chk("resume_enable", int'(bus.ntt_enable), 1);
    chk("resume_bn0_g101", int'(bus.bn[0]), 11);
    wait_done(1000, -1, 1'b0);
    chk("stall_done_latency", done_cyc - t0, 798);
    chk("g100_emitted_once", g100_cnt, 1);
    chk("stall_enable_count", en_cnt, 768);

    // reset asserted at stage 1 group 50
    clear_stats();
    pulse_start();
    wait_group("found_s1_g50", 1, 48, 5, 600);
    rst_n = 1'b0;
    #1;
    chk("midrst_enable", int'(bus.ntt_enable), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_stage", int'(bus.stage_idx), 0);
    chk("midrst_ma_or", int'(|bus.ma), 0);
    chk("midrst_bn_or", int'(|bus.bn), 0);
    repeat (20) @(negedge clk);
    chk("midrst_no_done", done_cnt, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("post_rst_done", done_cnt, 0);
    clear_stats();
    pulse_start();
    @(negedge clk); #1;
    chk("restart_enable", int'(bus.ntt_enable), 1);
    chk("restart_ma_k3", int'(bus.ma[3]), 48);
    chk("restart_bn_k3", int'(bus.bn[3]), 3);
    chk("restart_ma_k15", int'(bus.ma[15]), 240);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
